// File: rtl/mips_pkg.sv
// Shared MIPS-I decode definitions: opcodes, control field widths and the
// per-opcode control words consumed by the ID/EX register.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam int unsigned WB_W = 2;
    localparam int unsigned M_W  = 3;
    localparam int unsigned EX_W = 4;

    // ex = {RegDst, ALUOp[1:0], ALUSrc}, m = {Branch, MemRead, MemWrite},
    // wb = {RegWrite, MemtoReg}
    typedef struct packed {
        logic [EX_W-1:0] ex;
        logic [M_W-1:0]  m;
        logic [WB_W-1:0] wb;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = '{ex: 4'b0000, m: 3'b000, wb: 2'b00};
    localparam ctrl_t CTRL_RTYPE = '{ex: 4'b1100, m: 3'b000, wb: 2'b10};
    localparam ctrl_t CTRL_LW    = '{ex: 4'b0001, m: 3'b010, wb: 2'b11};
    localparam ctrl_t CTRL_SW    = '{ex: 4'b0001, m: 3'b001, wb: 2'b00};
    localparam ctrl_t CTRL_BEQ   = '{ex: 4'b0010, m: 3'b100, wb: 2'b00};

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        case (opcode)
            OP_RTYPE: decode_ctrl = CTRL_RTYPE;
            OP_LW:    decode_ctrl = CTRL_LW;
            OP_SW:    decode_ctrl = CTRL_SW;
            OP_BEQ:   decode_ctrl = CTRL_BEQ;
            default:  decode_ctrl = CTRL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one synchronous write port, $0 hardwired to zero.
module register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  read_idx_a,
    input  logic [4:0]  read_idx_b,
    output logic [31:0] read_data_a,
    output logic [31:0] read_data_b,
    input  logic        write_en,
    input  logic [4:0]  write_idx,
    input  logic [31:0] write_data
);

    logic [31:0] regs [32];
    logic        write_valid;

    assign write_valid = write_en && (write_idx != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (write_valid) begin
            regs[write_idx] <= write_data;
        end
    end

    // Bypass lets an instruction decoded in the write cycle see the new value.
    always_comb begin
        read_data_a = 32'h0;
        read_data_b = 32'h0;
        if (read_idx_a != 5'd0) begin
            read_data_a = (write_valid && write_idx == read_idx_a) ? write_data
                                                                   : regs[read_idx_a];
        end
        if (read_idx_b != 5'd0) begin
            read_data_b = (write_valid && write_idx == read_idx_b) ? write_data
                                                                   : regs[read_idx_b];
        end
    end

endmodule

// File: rtl/i_decode.sv
// MIPS instruction-decode stage: register read, control decode, sign extension
// and the ID/EX pipeline register.
module i_decode
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     IF_ID_IR,
    input  logic [31:0]     IF_ID_NPC,
    input  logic            MEM_WB_RegWrite,
    input  logic [4:0]      MEM_WB_WriteReg,
    input  logic [31:0]     WB_WriteData,
    input  logic            flush,
    output logic [WB_W-1:0] ID_EX_WB,
    output logic [M_W-1:0]  ID_EX_M,
    output logic [EX_W-1:0] ID_EX_EX,
    output logic [31:0]     ID_EX_NPC,
    output logic [31:0]     ID_EX_A,
    output logic [31:0]     ID_EX_B,
    output logic [31:0]     ID_EX_IMM,
    output logic [4:0]      ID_EX_rt,
    output logic [4:0]      ID_EX_rd
);

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    ctrl_t       ctrl;

    assign opcode  = IF_ID_IR[31:26];
    assign rs      = IF_ID_IR[25:21];
    assign rt      = IF_ID_IR[20:16];
    assign rd      = IF_ID_IR[15:11];
    assign imm     = IF_ID_IR[15:0];
    assign imm_ext = {{16{imm[15]}}, imm};

    // A flushed slot still carries its data fields; only control becomes a bubble.
    assign ctrl = flush ? CTRL_NONE : decode_ctrl(opcode);

    register_file u_register_file (
        .clk        (clk),
        .reset      (reset),
        .read_idx_a (rs),
        .read_idx_b (rt),
        .read_data_a(rs_data),
        .read_data_b(rt_data),
        .write_en   (MEM_WB_RegWrite),
        .write_idx  (MEM_WB_WriteReg),
        .write_data (WB_WriteData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ID_EX_WB  <= '0;
            ID_EX_M   <= '0;
            ID_EX_EX  <= '0;
            ID_EX_NPC <= 32'h0;
            ID_EX_A   <= 32'h0;
            ID_EX_B   <= 32'h0;
            ID_EX_IMM <= 32'h0;
            ID_EX_rt  <= 5'd0;
            ID_EX_rd  <= 5'd0;
        end else begin
            ID_EX_WB  <= ctrl.wb;
            ID_EX_M   <= ctrl.m;
            ID_EX_EX  <= ctrl.ex;
            ID_EX_NPC <= IF_ID_NPC;
            ID_EX_A   <= rs_data;
            ID_EX_B   <= rt_data;
            ID_EX_IMM <= imm_ext;
            ID_EX_rt  <= rt;
            ID_EX_rd  <= rd;
        end
    end

endmodule

// File: tb/tb_i_decode.sv
// Self-checking bench for i_decode: directed cases plus randomized traffic
// against an array-based reference of the register file and decode table.
module tb_i_decode;

    logic        clk;
    logic        reset;
    logic [31:0] IF_ID_IR;
    logic [31:0] IF_ID_NPC;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_WriteReg;
    logic [31:0] WB_WriteData;
    logic        flush;
    logic [1:0]  ID_EX_WB;
    logic [2:0]  ID_EX_M;
    logic [3:0]  ID_EX_EX;
    logic [31:0] ID_EX_NPC;
    logic [31:0] ID_EX_A;
    logic [31:0] ID_EX_B;
    logic [31:0] ID_EX_IMM;
    logic [4:0]  ID_EX_rt;
    logic [4:0]  ID_EX_rd;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] model_rf [32];

    i_decode dut (
        .clk            (clk),
        .reset          (reset),
        .IF_ID_IR       (IF_ID_IR),
        .IF_ID_NPC      (IF_ID_NPC),
        .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_WriteReg(MEM_WB_WriteReg),
        .WB_WriteData   (WB_WriteData),
        .flush          (flush),
        .ID_EX_WB       (ID_EX_WB),
        .ID_EX_M        (ID_EX_M),
        .ID_EX_EX       (ID_EX_EX),
        .ID_EX_NPC      (ID_EX_NPC),
        .ID_EX_A        (ID_EX_A),
        .ID_EX_B        (ID_EX_B),
        .ID_EX_IMM      (ID_EX_IMM),
        .ID_EX_rt       (ID_EX_rt),
        .ID_EX_rd       (ID_EX_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Table of control words, as {EX, M, WB}.
    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b1100_000_10;
            6'h23:   return 9'b0001_010_11;
            6'h2B:   return 9'b0001_001_00;
            6'h04:   return 9'b0010_100_00;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (we && wa == idx) return wd;
        return model_rf[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    endtask

    task automatic check_all_zero(input string where);
        check({where, " ctrl"}, {23'h0, ID_EX_EX, ID_EX_M, ID_EX_WB}, 32'h0);
        check({where, " npc"}, ID_EX_NPC, 32'h0);
        check({where, " a"}, ID_EX_A, 32'h0);
        check({where, " b"}, ID_EX_B, 32'h0);
        check({where, " imm"}, ID_EX_IMM, 32'h0);
        check({where, " rt_rd"}, {22'h0, ID_EX_rt, ID_EX_rd}, 32'h0);
    endtask

    // One decode cycle: drive at negedge, check ID/EX after the next posedge.
    task automatic step(input logic [31:0] ir, input logic [31:0] npc, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input logic fl);
        logic [31:0] exp_a, exp_b, exp_imm;
        logic [8:0]  exp_c;
        @(negedge clk);
        IF_ID_IR        = ir;
        IF_ID_NPC       = npc;
        MEM_WB_RegWrite = we;
        MEM_WB_WriteReg = wa;
        WB_WriteData    = wd;
        flush           = fl;
        exp_a   = ref_read(ir[25:21], we, wa, wd);
        exp_b   = ref_read(ir[20:16], we, wa, wd);
        exp_c   = fl ? 9'b0 : ref_ctrl(ir[31:26]);
        exp_imm = 32'(signed'(ir[15:0]));
        if (we && wa != 5'd0) model_rf[wa] = wd;
        @(posedge clk);
        #1;
        check("ctrl", {23'h0, ID_EX_EX, ID_EX_M, ID_EX_WB}, {23'h0, exp_c});
        check("npc", ID_EX_NPC, npc);
        check("a", ID_EX_A, exp_a);
        check("b", ID_EX_B, exp_b);
        check("imm", ID_EX_IMM, exp_imm);
        check("rt", {27'h0, ID_EX_rt}, {27'h0, ir[20:16]});
        check("rd", {27'h0, ID_EX_rd}, {27'h0, ir[15:11]});
    endtask

    task automatic wb_write(input logic [4:0] wa, input logic [31:0] wd);
        step(32'hFC00_0000, 32'h0, 1'b1, wa, wd, 1'b0);
    endtask

    initial begin
        logic [5:0]  ops [5];
        logic [31:0] ir;
        clear_model();
        reset = 1'b1;
        IF_ID_IR = 32'h0;
        IF_ID_NPC = 32'h0;
        MEM_WB_RegWrite = 1'b0;
        MEM_WB_WriteReg = 5'd0;
        WB_WriteData = 32'h0;
        flush = 1'b0;
        #1;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b0;

        step(32'h0000_0000, 32'h0000_0100, 1'b0, 5'd0, 32'h0, 1'b0);
        wb_write(5'd8, 32'h0000_00AA);
        wb_write(5'd9, 32'h0000_0011);
        step(32'h0109_5020, 32'h0000_0104, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'h0109_5020, 32'h0000_0108, 1'b1, 5'd8, 32'h0000_1234, 1'b0);
        step(32'h0109_5020, 32'h0000_010C, 1'b0, 5'd0, 32'h0, 1'b0);
        wb_write(5'd3, 32'h0000_0100);
        step(32'h8C62_FFFC, 32'h0000_0110, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'h8C02_0004, 32'h0000_0114, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
        step(32'h0000_0000, 32'h0000_0118, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'h1022_0003, 32'h0000_011C, 1'b0, 5'd0, 32'h0, 1'b1);
        step(32'hFC00_0000, 32'h0000_0120, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'hAD09_0008, 32'h0000_0124, 1'b0, 5'd0, 32'h0, 1'b0);

        // Asynchronous reset with a write in flight: the write must be lost.
        wb_write(5'd5, 32'h5555_0000);
        @(negedge clk);
        MEM_WB_RegWrite = 1'b1;
        MEM_WB_WriteReg = 5'd5;
        WB_WriteData    = 32'hCAFE_F00D;
        IF_ID_IR        = 32'h00A5_2820;
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        clear_model();
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        MEM_WB_RegWrite = 1'b0;
        step(32'h00A8_2820, 32'h0000_0200, 1'b0, 5'd0, 32'h0, 1'b0);

        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
        for (int n = 0; n < 400; n++) begin
            ops[4] = 6'($urandom);
            ir = $urandom;
            ir[31:26] = ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) ir[25:21] = 5'd0;
            step(ir, $urandom, 1'($urandom), 5'($urandom_range(0, 7) == 0 ? 0 : $urandom),
                 $urandom, $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i_decode.md
# i_decode

Instruction-decode stage of the five-stage MIPS pipeline. It sits directly downstream of the fetch stage and consumes its IF/ID outputs (instruction word and next PC). It holds the 32×32 register file, decodes control for R-type/lw/sw/beq, and sign-extends the immediate. All results are captured into the ID/EX pipeline register for the execute stage. Register writes come back from the write-back stage.

## Interface
Parameters:
- none; all widths are fixed by the MIPS-I ISA (32-bit data, 5-bit register index).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears the register file and ID/EX
- IF_ID_IR  in  32  instruction from the IF/ID register
- IF_ID_NPC  in  32  PC+4 from the IF/ID register
- MEM_WB_RegWrite  in  1  write-back enable
- MEM_WB_WriteReg  in  5  write-back destination register
- WB_WriteData  in  32  write-back data
- flush  in  1  when high, the ID/EX control fields are captured as zero (bubble)
- ID_EX_WB  out  2  {RegWrite, MemtoReg}
- ID_EX_M  out  3  {Branch, MemRead, MemWrite}
- ID_EX_EX  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- ID_EX_NPC  out  32  registered IF_ID_NPC
- ID_EX_A  out  32  registered rs value
- ID_EX_B  out  32  registered rt value
- ID_EX_IMM  out  32  registered sign-extended IR[15:0]
- ID_EX_rt  out  5  registered IR[20:16]
- ID_EX_rd  out  5  registered IR[15:11]

## Operation
- Field split: opcode=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], imm=IR[15:0].
- Control decode is combinational from opcode and gives {EX, M, WB}:
  - R-type 0x00 → 1100, 000, 10
  - lw 0x23 → 0001, 010, 11
  - sw 0x2B → 0001, 001, 00
  - beq 0x04 → 0010, 100, 00
  - any other opcode → all zero
- Register file: 32×32, two combinational read ports (rs, rt) and one synchronous write port.
  - Write on posedge when MEM_WB_RegWrite=1 and MEM_WB_WriteReg≠0.
  - Register $0 always reads 0, and writes to it are discarded.
- Write-through bypass: if a read index equals MEM_WB_WriteReg, RegWrite=1 and the index is not 0, that read port returns WB_WriteData in the same cycle. This replaces the classic half-cycle write/read split.
- Sign extension: IMM = {{16{imm[15]}}, imm}.
- flush=1 zeroes ID_EX_WB, ID_EX_M and ID_EX_EX. The data fields (NPC, A, B, IMM, rt, rd) are still captured. The register-file write still occurs.

## Timing
- ID/EX register: every posedge captures the decode of the current IF_ID_* inputs. Latency is 1 cycle, with no stall and no enable.
- Register-file write and ID/EX capture happen on the same edge. The bypass guarantees that a register written in cycle N is seen by an instruction decoded in cycle N.
- Reset is asynchronous. While reset=1 and after it:
  - every ID/EX output is 0;
  - all 32 registers are 0.
  - Reset asserted mid-operation discards any in-flight write on that edge.
- Reset deassertion: the first capture happens on the first posedge with reset=0.
- Write and read of $0 in the same cycle: the read returns 0 and no bypass occurs.

## Structure
- Package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ;
  - control field widths (WB_W=2, M_W=3, EX_W=4);
  - a control-word struct with the per-opcode encodings above.
- One sub-module, register_file, contains the storage array, the $0 rule, the write port and the bypass.
- Control decode, sign extension and the ID/EX register stay inline in i_decode.

## Test plan
- Reset: assert reset mid-stream → all ID_EX_* outputs read 0 immediately (asynchronous). After release, decoding 0x00000000 gives A=B=0, EX=1100, WB=10.
- R-type: preload $8=0x000000AA and $9=0x00000011 via the WB port, then IR=0x01095020 (add $10,$8,$9) with NPC=0x104 → next edge: A=0xAA, B=0x11, rt=9, rd=10, EX=1100, M=000, WB=10, NPC=0x104.
- Bypass: in the same cycle, WB writes $8=0x00001234 while IR=0x01095020 → A=0x00001234. On the following cycle, rereading $8 without a write still gives 0x00001234.
- lw: $3=0x100, IR=0x8C62FFFC → A=0x100, IMM=0xFFFFFFFC, rt=2, EX=0001, M=010, WB=11.
- $0 protection: WB writes $0=0xDEADBEEF while IR reads rs=0 → A=0. Later reads of $0 also return 0.
- Bubbles:
  - flush=1 with IR=0x10220003 (beq) → EX/M/WB=0, IMM=0x00000003, rt=2.
  - Opcode 0x3F with flush=0 → all control fields 0.
